audio_sd_dac: RTL and testbench



---
 rtl/audio_pkg.sv | 12 +
 rtl/sample_fifo.sv | 54 +++++
 rtl/audio_sd_dac.sv | 130 +++++++++++++
 tb/tb_audio_sd_dac.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the headphone output path: default widths, gain width,
// the midscale idle code and the sample-period divider.
package audio_pkg;
  localparam int DEF_IN_W       = 16;
  localparam int DEF_OUT_W      = 4;
  localparam int DEF_SAMPLE_DIV = 32;
  localparam int GAIN_W         = 4;

  localparam logic [DEF_OUT_W-1:0] MIDSCALE_CODE = 4'b1000;

  typedef logic [GAIN_W-1:0] gain_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with occupancy output; reading is fall-through (dout shows the head).
module sample_fifo
  import audio_pkg::*;
#(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int LVL_W  = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     full,
  output logic                     empty,
  output logic [LVL_W-1:0]         level
);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_sd_dac.sv
// Headphone output stage: buffers PCM samples, pops one per sample period, applies a
// ramped gain and drives a first-order noise-shaped OUT_W-bit code every clock.
module audio_sd_dac
  import audio_pkg::*;
#(
  parameter int  IN_W       = DEF_IN_W,
  parameter int  OUT_W      = DEF_OUT_W,
  parameter int  FIFO_DEPTH = 8,
  parameter int  SAMPLE_DIV = DEF_SAMPLE_DIV,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [GAIN_W-1:0]      volume,
  input  logic                   mute,
  output logic [OUT_W-1:0]       out_audio,
  output logic                   sample_tick,
  output logic                   underrun,
  output logic [7:0]             underrun_cnt,
  output logic [LVL_W-1:0]       fifo_level
);

  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int ERR_W  = IN_W - OUT_W;
  localparam int PROD_W = IN_W + 5;

  function automatic logic signed [IN_W-1:0] scale_sample(input logic signed [IN_W-1:0] s,
                                                          input gain_t g);
    logic signed [PROD_W-1:0] prod;
    prod = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
    return IN_W'(prod >>> 4);
  endfunction

  // Offset-binary accumulate; a carry out saturates the code and clears the residue.
  function automatic logic [IN_W-1:0] modulate(input logic signed [IN_W-1:0] held,
                                               input logic [ERR_W-1:0] err);
    logic [IN_W:0] sum;
    sum = {1'b0, ~held[IN_W-1], held[IN_W-2:0]} + {{(OUT_W+1){1'b0}}, err};
    if (sum[IN_W]) return {{OUT_W{1'b1}}, {ERR_W{1'b0}}};
    return sum[IN_W-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  function automatic gain_t gain_step(input gain_t g, input gain_t tgt);
    if (g < tgt) return g + GAIN_W'(1);
    if (g > tgt) return g - GAIN_W'(1);
    return g;
  endfunction

  logic [CNT_W-1:0]       tick_cnt;
  gain_t                  gain;
  gain_t                  gain_target;
  logic                   tick;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic signed [IN_W-1:0] fifo_dout;
  logic signed [IN_W-1:0] sample_p0;
  logic                   vld_p0;
  logic signed [IN_W-1:0] held_p1;
  logic [OUT_W-1:0]       out_p2;
  logic [ERR_W-1:0]       err_p2;

  sample_fifo #(
    .DATA_W (IN_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign tick        = (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign in_ready    = ~fifo_full;
  assign push        = in_valid & ~fifo_full;
  assign pop         = tick & ~fifo_empty;
  assign sample_tick = tick;
  assign underrun    = tick & fifo_empty;
  assign gain_target = mute ? '0 : volume;
  assign out_audio   = out_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt     <= '0;
      gain         <= '0;
      underrun_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (tick) gain <= gain_step(gain, gain_target);
      if (underrun) underrun_cnt <= sat_inc8(underrun_cnt);
    end
  end

  // p0: head sample (or silence on underrun) popped at the tick
  assign vld_p0    = tick;
  assign sample_p0 = fifo_empty ? '0 : fifo_dout;

  // p1: scaled sample held for the whole period, using the gain before this tick's step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_p1 <= '0;
    end else if (vld_p0) begin
      held_p1 <= scale_sample(sample_p0, gain);
    end
  end

  // p2: noise-shaped output code, updated every clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p2 <= MIDSCALE_CODE;
      err_p2 <= '0;
    end else begin
      {out_p2, err_p2} <= modulate(held_p1, err_p2);
    end
  end

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac: reset state, underrun counting, gain ramp, scaling,
// FIFO back-pressure, mute ramp-down and asynchronous reset mid-stream.
module tb_audio_sd_dac;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         volume;
  logic               mute;
  logic [3:0]         out_audio;
  logic               sample_tick;
  logic               underrun;
  logic [7:0]         underrun_cnt;
  logic [3:0]         fifo_level;

  int checks   = 0;
  int failures = 0;

  audio_sd_dac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .volume       (volume),
    .mute         (mute),
    .out_audio    (out_audio),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset is released on a negedge; that negedge is cycle 0 and ticks fall on 32k+31.
  task automatic reset_release();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic measure(output int sum, output int mx);
    sum = 0;
    mx  = 0;
    repeat (32) begin
      sum += int'(out_audio);
      if (int'(out_audio) > mx) mx = int'(out_audio);
      step(1);
    end
  endtask

  int nund;
  int sum;
  int mx;
  bit allmid;

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    volume   = 4'd0;
    mute     = 1'b0;
    step(2);

    chk("rst_out_audio", {28'h0, out_audio}, 32'h8);
    chk("rst_fifo_level", {28'h0, fifo_level}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_sample_tick", {31'h0, sample_tick}, 32'h0);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    chk("rst_underrun_cnt", {24'h0, underrun_cnt}, 32'h0);

    // Idle: one underrun per period, midscale output, saturating counter.
    rst_n  = 1'b1;
    nund   = 0;
    allmid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (underrun) nund++;
      if (out_audio !== 4'h8) allmid = 1'b0;
    end
    chk("idle_underrun_pulses", nund, 1);
    chk("idle_out_midscale", {31'h0, allmid}, 32'h1);
    chk("idle_underrun_cnt_1", {24'h0, underrun_cnt}, 32'd1);
    step(32 * 99);
    chk("idle_underrun_cnt_100", {24'h0, underrun_cnt}, 32'd100);
    step(32 * 156);
    chk("idle_underrun_cnt_sat", {24'h0, underrun_cnt}, 32'd255);
    chk("idle_out_after_sat", {28'h0, out_audio}, 32'h8);

    // Full-scale positive with volume 15: ramp then constant top code.
    in_data  = 16'sh7FFF;
    in_valid = 1'b1;
    volume   = 4'd15;
    reset_release();
    nund = 0;
    for (int i = 0; i < 480; i++) begin
      if (i == 160) chk("pos_gain_5", {28'h0, dut.gain}, 32'd5);
      if (underrun) nund++;
      step(1);
    end
    chk("pos_no_underrun", nund, 0);
    chk("pos_gain_15", {28'h0, dut.gain}, 32'd15);
    step(64);
    chk("pos_held", {16'h0, dut.held_p1}, 32'h77FF);
    measure(sum, mx);
    chk("pos_density_sum", sum, 480);

    // Full-scale negative: code alternates 0/1 (offset 0x0800 accumulates half a step).
    in_data = 16'sh8000;
    reset_release();
    step(544);
    chk("neg_held", {16'h0, dut.held_p1}, 32'h8800);
    measure(sum, mx);
    chk("neg_density_sum", sum, 16);
    chk("neg_max_code", mx, 1);
    chk("neg_no_underrun", {24'h0, underrun_cnt}, 32'd0);

    // Back-pressure: 9 back-to-back pushes, no tick before cycle 31.
    in_valid = 1'b0;
    in_data  = '0;
    reset_release();
    for (int k = 1; k <= 8; k++) begin
      in_data  = 16'(k * 16'h0800);
      in_valid = 1'b1;
      step(1);
    end
    in_data = 16'sh4800;
    chk("bp_level_full", {28'h0, fifo_level}, 32'd8);
    chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    step(23);
    chk("bp_tick_31", {31'h0, sample_tick}, 32'h1);
    chk("bp_level_at_tick", {28'h0, fifo_level}, 32'd8);
    step(1);
    chk("bp_level_after_pop", {28'h0, fifo_level}, 32'd7);
    chk("bp_in_ready_high", {31'h0, in_ready}, 32'h1);
    step(1);
    chk("bp_ninth_accepted", {28'h0, fifo_level}, 32'd8);
    in_valid = 1'b0;
    step(31);
    chk("bp_held_pop2", {16'h0, dut.held_p1}, 32'h0100);
    step(32);
    chk("bp_held_pop3", {16'h0, dut.held_p1}, 32'h0300);
    step(192);
    chk("bp_held_pop9", {16'h0, dut.held_p1}, 32'h2400);
    step(31);
    chk("bp_underrun_empty", {31'h0, underrun}, 32'h1);
    in_data  = 16'sh7000;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("bp_push_on_underrun_kept", {28'h0, fifo_level}, 32'd1);
    chk("bp_underrun_cnt", {24'h0, underrun_cnt}, 32'd1);
    chk("bp_held_silence", {16'h0, dut.held_p1}, 32'h0);
    step(32);
    chk("bp_held_late_pop", {16'h0, dut.held_p1}, 32'h4600);
    chk("bp_underrun_cnt_still", {24'h0, underrun_cnt}, 32'd1);

    // Mute from gain 15 with constant 0x4000: gain steps down once per tick.
    in_data  = 16'sh4000;
    in_valid = 1'b1;
    mute     = 1'b0;
    reset_release();
    step(544);
    chk("mute_gain_start", {28'h0, dut.gain}, 32'd15);
    mute = 1'b1;
    step(256);
    chk("mute_gain_mid", {28'h0, dut.gain}, 32'd7);
    step(224);
    chk("mute_gain_zero", {28'h0, dut.gain}, 32'd0);
    chk("mute_held_gain1", {16'h0, dut.held_p1}, 32'h0400);
    step(33);
    measure(sum, mx);
    chk("mute_out_sum", sum, 256);
    chk("mute_out_max", mx, 8);

    // Asynchronous reset with 5 entries queued.
    mute     = 1'b0;
    in_data  = 16'sh7FFF;
    in_valid = 1'b1;
    reset_release();
    step(96);
    in_valid = 1'b0;
    step(64);
    chk("ar_level_before", {28'h0, fifo_level}, 32'd5);
    chk("ar_gain_before", {28'h0, dut.gain}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_level_cleared", {28'h0, fifo_level}, 32'd0);
    chk("ar_out_midscale", {28'h0, out_audio}, 32'h8);
    chk("ar_gain_cleared", {28'h0, dut.gain}, 32'd0);
    chk("ar_in_ready", {31'h0, in_ready}, 32'h1);
    step(1);
    rst_n = 1'b1;
    step(31);
    chk("ar_first_tick_underrun", {31'h0, underrun}, 32'h1);
    step(1);
    chk("ar_no_old_data", {16'h0, dut.held_p1}, 32'h0);
    chk("ar_underrun_cnt", {24'h0, underrun_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
